// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the four-channel TDM demultiplexer: FSM states,
// channel count and counter sizing helper.
package tdm_demux4_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } tdm_state_e;

  localparam int unsigned TDM_CH = 4;

  // Bit-counter width for a W-bit slot; never narrower than one bit.
  function automatic int unsigned bit_cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// W-bit serial-in, parallel-out register, MSB first, with synchronous clear.
module sipo_shift #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q,
  output logic [W-1:0] q_nxt_c
);

  // Value after one shift; lets the parent capture the final bit without a cycle of delay.
  assign q_nxt_c = W'({q, din});

  // A shift takes priority so a clear can coincide with the first bit of a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= q_nxt_c;
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: hunts for the frame sync, deserializes four W-bit
// slots MSB first and presents them together with a one-cycle valid strobe.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  input  logic         sync,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic         valid,
  output logic         frame_err,
  output logic         locked
);

  localparam int unsigned BW = bit_cnt_width(W);

  tdm_state_e      state, state_nxt;
  logic [1:0]      slot_cnt, slot_nxt;
  logic [BW-1:0]   bit_cnt, bit_nxt;
  logic [TDM_CH-1:0] shift_en_c;
  logic            clr_c;
  logic            load_c;
  logic            valid_c;
  logic            err_c;

  logic [W-1:0]    slot_q     [TDM_CH];
  logic [W-1:0]    slot_nxt_c [TDM_CH];
  logic [W-1:0]    word_c     [TDM_CH];

  // One shift register per channel slot; only the active slot shifts.
  for (genvar g = 0; g < TDM_CH; g++) begin : g_slot
    sipo_shift #(.W(W)) u_sipo (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_c),
      .shift_en (shift_en_c[g]),
      .din      (din),
      .q        (slot_q[g]),
      .q_nxt_c  (slot_nxt_c[g])
    );
  end

  // Slot contents including the bit being accepted this cycle.
  always_comb begin
    for (int i = 0; i < int'(TDM_CH); i++) begin
      word_c[i] = shift_en_c[i] ? slot_nxt_c[i] : slot_q[i];
    end
  end

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot_cnt;
    bit_nxt    = bit_cnt;
    shift_en_c = '0;
    clr_c      = 1'b0;
    load_c     = 1'b0;
    valid_c    = 1'b0;
    err_c      = 1'b0;

    if (en) begin
      // The bit is frame bit 0 when it carries sync and is accepted as a frame start.
      if (sync && (state == ST_HUNT || slot_cnt != 2'd0 || bit_cnt != '0 ||
                   state == ST_RECV)) begin
        if (state == ST_RECV && (slot_cnt != 2'd0 || bit_cnt != '0)) begin
          err_c = 1'b1;
        end
        state_nxt     = ST_RECV;
        clr_c         = 1'b1;
        shift_en_c[0] = 1'b1;
        slot_nxt      = (W == 1) ? 2'd1 : 2'd0;
        bit_nxt       = (W == 1) ? '0 : BW'(1);
      end else if (state == ST_RECV) begin
        if (slot_cnt == 2'd0 && bit_cnt == '0) begin
          // Missing sync after a completed frame: drop the bit and re-hunt.
          err_c     = 1'b1;
          state_nxt = ST_HUNT;
        end else begin
          shift_en_c[slot_cnt] = 1'b1;
          if (bit_cnt == BW'(W - 1)) begin
            bit_nxt  = '0;
            slot_nxt = slot_cnt + 2'd1;
            if (slot_cnt == 2'd3) begin
              load_c  = 1'b1;
              valid_c = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HUNT;
      slot_cnt  <= 2'd0;
      bit_cnt   <= '0;
      A         <= '0;
      B         <= '0;
      C         <= '0;
      D         <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_nxt;
      bit_cnt   <= bit_nxt;
      valid     <= valid_c;
      frame_err <= err_c;
      locked    <= (state_nxt == ST_RECV);
      if (load_c) begin
        A <= word_c[0];
        B <= word_c[1];
        C <= word_c[2];
        D <= word_c[3];
      end
    end
  end

endmodule
